// File: rtl/nibble_packer_pkg.sv
// -----------------------------------------------------------------------------
// nibble_packer_pkg
// Shared definitions for the barrel shifter and nibble_packer.
//   NIBBLE_W                  - width of one nibble (shared with the shifter)
//   nibble_t                  - one nibble
//   DEFAULT_NIBBLES_PER_WORD  - default packing factor of nibble_packer
// -----------------------------------------------------------------------------
package nibble_packer_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    localparam int DEFAULT_NIBBLES_PER_WORD = 4;

endpackage : nibble_packer_pkg

// File: rtl/nibble_packer_word_out_reg.sv
// -----------------------------------------------------------------------------
// word_out_reg
// Registered output slice of nibble_packer. Holds one completed word until
// the consumer takes it, and counts emitted words.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits for ready, and ready never looks at valid/data of
// the same side.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           a completed word is presented this cycle (only when in_ready)
//   load_data      completed word, slots above the last nibble already zero
//   load_count     number of meaningful nibbles in load_data
//   out_ready      consumer takes the held word this cycle
//   out_valid      out_data holds a completed word
//   out_data       held word
//   out_count      meaningful nibbles in out_data
//   word_cnt       words emitted so far, wraps 255 -> 0
//   in_ready       slice can take a new word this cycle
// -----------------------------------------------------------------------------
module word_out_reg #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic [7:0]        word_cnt,
    output logic              in_ready
);

    logic out_fire;

    // Register-only ready: a held word blocks new words unless it leaves now.
    assign in_ready = !out_valid || out_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            word_cnt  <= '0;
        end else begin
            // A new word replaces a departing one on the same edge.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_count <= load_count;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (out_fire) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

endmodule : word_out_reg

// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
// Packs consecutive 4-bit nibbles (first nibble least significant) into a
// word of NIBBLES_PER_WORD nibbles. in_last closes a partial word, zero-padded.
// Completed words sit in a registered output slice (word_out_reg).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits for ready, and ready never looks at valid/data of
// the same side.
//
// Parameters:
//   NIBBLES_PER_WORD  nibbles per word, legal range 2..8
//   WORD_W            4*NIBBLES_PER_WORD (derived)
//   CNT_W             $clog2(NIBBLES_PER_WORD+1) (derived)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input nibble handshake
//   in_data               nibble to pack
//   in_last               nibble closes the current word
//   out_valid/out_ready   output word handshake
//   out_data              packed word, nibble k at [4k+3:4k]
//   out_count             meaningful nibbles in out_data
//   word_cnt              words emitted, wraps 255 -> 0
// -----------------------------------------------------------------------------
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter  int NIBBLES_PER_WORD = DEFAULT_NIBBLES_PER_WORD,
    localparam int WORD_W           = NIBBLE_W * NIBBLES_PER_WORD,
    localparam int CNT_W            = $clog2(NIBBLES_PER_WORD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  nibble_t           in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic [7:0]        word_cnt
);

    localparam int IDX_W = $clog2(NIBBLES_PER_WORD);

    // idx is the accumulator state: 0 means EMPTY, anything else FILL.
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;

    logic              in_fire;
    logic              complete;
    logic [WORD_W-1:0] word_next;
    logic [CNT_W-1:0]  count_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else begin
            idx <= idx_next;
            acc <= acc_next;
        end
    end

    always_comb begin
        in_fire    = in_valid && in_ready;
        complete   = in_fire &&
                     ((idx == IDX_W'(NIBBLES_PER_WORD - 1)) || in_last);
        count_next = CNT_W'(idx) + CNT_W'(1);

        // Accumulated slots below idx, incoming nibble at idx, zeros above.
        word_next = '0;
        for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
            if (IDX_W'(k) < idx) begin
                word_next[NIBBLE_W*k +: NIBBLE_W] = acc[NIBBLE_W*k +: NIBBLE_W];
            end else if (IDX_W'(k) == idx) begin
                word_next[NIBBLE_W*k +: NIBBLE_W] = in_data;
            end
        end

        idx_next = idx;
        acc_next = acc;
        if (complete) begin
            idx_next = '0;
            acc_next = '0;
        end else if (in_fire) begin
            idx_next = idx + IDX_W'(1);
            acc_next = word_next;
        end
    end

    word_out_reg #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_word_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (complete),
        .load_data  (word_next),
        .load_count (count_next),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .word_cnt   (word_cnt),
        .in_ready   (in_ready)
    );

endmodule : nibble_packer

// File: doc/nibble_packer.md
# nibble_packer

Downstream stage of the 4-bit barrel shifter. Accepts one rotated nibble per cycle over a valid/ready handshake and packs consecutive nibbles, first nibble least significant, into a wide word. Completed words are held in a registered output stage with its own valid/ready handshake. An `in_last` marker flushes a partial word zero-padded, and a wrapping counter records how many words have been emitted.

## Interface
- `NIBBLES_PER_WORD`, default 4: nibbles per output word; legal range 2..8.
- `WORD_W`, derived as 4*NIBBLES_PER_WORD: output word width; not overridable.
- `CNT_W`, derived as $clog2(NIBBLES_PER_WORD+1): width of `out_count`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` holds a nibble.
- `in_ready`  out  1  block accepts a nibble this cycle.
- `in_data`  in  4  rotated nibble from the barrel shifter.
- `in_last`  in  1  this nibble closes the current word; qualified by `in_valid`.
- `out_valid`  out  1  `out_data` holds a completed word.
- `out_ready`  in  1  consumer takes the word this cycle.
- `out_data`  out  WORD_W  packed word; nibble k occupies bits [4k+3:4k].
- `out_count`  out  CNT_W  number of meaningful nibbles in `out_data` (1..NIBBLES_PER_WORD).
- `word_cnt`  out  8  words emitted so far; wraps 255 -> 0.

## Operation
- Input transfer occurs when `in_valid` && `in_ready`.
- Output transfer occurs when `out_valid` && `out_ready`.
- `in_ready` = !`out_valid` || `out_ready`.
  - It is registered-state based and never depends on `in_valid`, `in_data` or `in_last`.
  - It stalls the input whenever the output register holds an unconsumed word, including for nibbles that would not complete a word.
- Accumulator: register `acc` (WORD_W bits) and fill index `idx` (0..NIBBLES_PER_WORD-1).
  - `idx` acts as the state: EMPTY when `idx`=0, FILL otherwise.
- On an input transfer, `in_data` is written to nibble slot `idx` of the word.
- The word completes when `idx` = NIBBLES_PER_WORD-1 or `in_last`=1.
  - On completion, `out_data` is loaded with the accumulated nibbles plus the incoming nibble; slots above `idx` are forced to 0.
  - `out_count` is loaded with `idx`+1, `out_valid` is set, `idx` returns to 0 and `acc` clears.
- On a non-completing transfer, `idx` increments by 1.
- On an output transfer without a simultaneous completion, `out_valid` clears and `word_cnt` increments by 1.
- Simultaneous output transfer and completion:
  - The new word replaces the old one in the same edge.
  - `out_valid` stays 1 and `word_cnt` increments.
- `in_last` asserted with `idx`=0 produces a 1-nibble word with `out_count`=1.
- `in_last` is ignored when `in_valid`=0.
- `out_data`, `out_count` and `word_cnt` are stable whenever `out_valid`=1 && `out_ready`=0.
- No error state exists; the handshake makes overflow impossible.

## Timing
- Reset, while `rst_n` is low, asynchronously:
  - `idx`=0 and `acc`=0.
  - `out_valid`=0, `out_data`=0, `out_count`=0, `word_cnt`=0.
  - `in_ready`=1, following from `out_valid`=0.
- Reset mid-operation discards both the partial word and any pending output word.
- The first input transfer may occur on the first rising edge after `rst_n` rises.
- Latency: `out_valid` rises on the edge that accepts the completing nibble, one cycle after the nibble is presented with `in_ready` high.
- Throughput: one nibble per cycle sustained while `out_ready` is held 1, giving one word every NIBBLES_PER_WORD cycles.
- Backpressure: with `out_ready`=0 and `out_valid`=1, `in_ready` is 0 in the same cycle and stays 0 until the output transfer completes.

## Structure
- The shared package holds:
  - `NIBBLE_W`=4, used by both the barrel shifter and this block.
  - A typedef for a nibble.
  - The default NIBBLES_PER_WORD constant.
- One sub-module is natural: `word_out_reg`, the output register slice.
  - It holds `out_valid`, `out_data`, `out_count` and `word_cnt`.
  - It generates `in_ready`.
- Accumulator logic stays in the top module.

## Test plan
- Reset then stream 1,2,3,4 with `out_ready`=1 -> one cycle later `out_valid`=1, `out_data`=16'h4321, `out_count`=4, `word_cnt` becomes 1 after the transfer.
- Stream A,B then `in_last` on C -> `out_data`=16'h0CBA and `out_count`=3; the next word starts at slot 0.
- `in_last` on a lone nibble F from EMPTY -> `out_data`=16'h000F and `out_count`=1.
- Complete word 16'h8765 with `out_ready`=0 for 5 cycles -> `in_ready`=0 throughout and `out_data` holds; when `out_ready` rises, the transfer occurs and `in_ready` returns to 1 in the same cycle.
- Continuous stream of 8 nibbles with `out_ready`=1 -> words 16'h4321 then 16'h8765 back-to-back with `in_ready` never low.
- Assert `rst_n` low after 2 nibbles and while a word is pending -> all outputs reset to 0 immediately; a subsequent stream of 4 nibbles yields a correct word with `word_cnt`=1.
- Run 256 words -> `word_cnt` wraps to 0.
